// File: rtl/apb_master.sv
// APB requester: turns single host commands into APB SETUP/ACCESS transfers.
// An ACCESS phase that waits too long is aborted and reported as a timeout.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       done;
  logic       expire;

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_nx = SETUP;
      end
      SETUP: begin
        psel     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        done    = pready;
        // pready wins over the timeout in the last allowed cycle
        expire  = !pready && (wait_cnt == LAST);
        if (done || expire) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= done || expire;
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !pready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (done) begin
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model with a RAM completer,
// checked every cycle plus a few literal latency/data expectations.
module tb_apb_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  apb_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  // model expectations for the current cycle
  logic              e_ready, e_psel, e_pen, e_rv;
  logic              e_err, e_to, e_pwrite;
  logic [DATA_W-1:0] e_rdata, e_pwdata;
  logic [ADDR_W-1:0] e_paddr;
  bit                pend;
  logic [DATA_W-1:0] p_rdata;
  logic              p_err, p_to;

  logic [DATA_W-1:0] ram [32];
  logic [DATA_W-1:0] ref_mem [32];

  int rsp_cnt = 0;
  int acc_cnt = 0;
  int last_rsp = 0;
  int last_acc = -100;
  int acc_cyc = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    n_total++;
    if (a !== e) begin
      $display("FAIL %s actual=%h required=%h cyc=%0d", n, a, e, cyc);
    end else begin
      n_pass++;
    end
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      chk("psel", 64'(psel), 64'(e_psel));
      chk("penable", 64'(penable), 64'(e_pen));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      chk("rsp_slverr", 64'(rsp_slverr), 64'(e_err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
      chk("pwrite", 64'(pwrite), 64'(e_pwrite));
      chk("paddr", 64'(paddr), 64'(e_paddr));
      chk("pwdata", 64'(pwdata), 64'(e_pwdata));
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        last_rsp = cyc;
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        chk("acc_gap", 64'(cyc - last_acc >= 3), 64'd1);
        acc_cnt++;
        last_acc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic rsp_slot();
    e_rv = pend;
    if (pend) begin
      e_rdata = p_rdata;
      e_err   = p_err;
      e_to    = p_to;
    end
    pend = 1'b0;
  endtask

  task automatic noise(input bit hold);
    cmd_valid = hold;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    pready    = 1'($urandom);
    pslverr   = 1'($urandom);
    prdata    = $urandom;
  endtask

  task automatic idle_cycle();
    noise(1'b0);
    e_ready = 1'b1;
    e_psel  = 1'b0;
    e_pen   = 1'b0;
    rsp_slot();
    step();
  endtask

  task automatic reset_model();
    e_ready  = 1'b1;
    e_psel   = 1'b0;
    e_pen    = 1'b0;
    e_rv     = 1'b0;
    e_rdata  = '0;
    e_err    = 1'b0;
    e_to     = 1'b0;
    e_pwrite = 1'b0;
    e_paddr  = '0;
    e_pwdata = '0;
    pend     = 1'b0;
  endtask

  // one command; w = pready-low cycles before pready, rst_at = ACCESS
  // cycle index where reset is applied (-1 for none)
  task automatic txn(input bit wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input int w,
                     input bit err, input bit hold, input int rst_at);
    int i;
    bit fin;
    noise(1'b1);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    e_ready = 1'b1;
    e_psel  = 1'b0;
    e_pen   = 1'b0;
    rsp_slot();
    acc_cyc = cyc;
    step();
    e_pwrite = wr;
    e_paddr  = a;
    e_pwdata = d;
    noise(hold);
    e_ready = 1'b0;
    e_psel  = 1'b1;
    e_pen   = 1'b0;
    rsp_slot();
    step();
    i = 0;
    fin = 1'b0;
    while (!fin) begin
      noise(hold);
      pready = (i == w);
      if (i == w) begin
        pslverr = err;
        prdata  = ram[paddr[6:2]];
        if (pwrite === 1'b1) ram[paddr[6:2]] = pwdata;
      end
      e_ready = 1'b0;
      e_psel  = 1'b1;
      e_pen   = 1'b1;
      rsp_slot();
      preset = (i == rst_at);
      step();
      if (i == rst_at) begin
        preset = 1'b0;
        reset_model();
        fin = 1'b1;
      end else if (i == w) begin
        pend    = 1'b1;
        p_rdata = wr ? '0 : ref_mem[a[6:2]];
        p_err   = err;
        p_to    = 1'b0;
        if (wr) ref_mem[a[6:2]] = d;
        fin = 1'b1;
      end else if (i == TIMEOUT - 1) begin
        pend    = 1'b1;
        p_rdata = '0;
        p_err   = 1'b1;
        p_to    = 1'b1;
        fin = 1'b1;
      end
      i++;
    end
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    logic [ADDR_W-1:0] r;
    r = '0;
    r[6:2] = 5'($urandom_range(0, 31));
    return r;
  endfunction

  initial begin
    int r0, a0, w;
    for (int k = 0; k < 32; k++) begin
      ram[k] = $urandom;
      ref_mem[k] = ram[k];
    end
    reset_model();
    preset = 1'b1;
    noise(1'b0);
    step();
    chk_en = 1'b1;
    noise(1'b0);
    step();
    preset = 1'b0;
    idle_cycle();

    txn(1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 1'b0, -1);
    idle_cycle();
    chk("lat_write0", 64'(last_rsp - acc_cyc), 64'd3);

    txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b0, -1);
    idle_cycle();
    chk("lat_read3", 64'(last_rsp - acc_cyc), 64'd6);
    chk("read_lit", 64'(rsp_rdata), 64'hA5A5_0001);

    txn(1'b0, 32'h40, 32'h0, 0, 1'b1, 1'b0, -1);
    idle_cycle();
    chk("err_slverr", 64'(rsp_slverr), 64'd1);
    chk("err_to", 64'(rsp_timeout), 64'd0);

    txn(1'b0, 32'h20, 32'h0, TIMEOUT + 3, 1'b0, 1'b0, -1);
    idle_cycle();
    chk("lat_tmo", 64'(last_rsp - acc_cyc), 64'd18);
    chk("tmo_flag", 64'(rsp_timeout), 64'd1);
    chk("tmo_rdata", 64'(rsp_rdata), 64'd0);

    txn(1'b1, 32'h20, 32'h1234_5678, TIMEOUT - 1, 1'b0, 1'b0, -1);
    idle_cycle();
    chk("lat_last", 64'(last_rsp - acc_cyc), 64'd18);
    chk("last_to", 64'(rsp_timeout), 64'd0);

    r0 = rsp_cnt;
    txn(1'b0, 32'h20, 32'h0, 10, 1'b0, 1'b0, 1);
    idle_cycle();
    idle_cycle();
    chk("rst_norsp", 64'(rsp_cnt - r0), 64'd0);

    r0 = rsp_cnt;
    a0 = acc_cnt;
    for (int k = 0; k < 20; k++) begin
      txn(1'($urandom), rnd_addr(), $urandom, $urandom_range(0, 4),
          1'($urandom), 1'b1, -1);
    end
    idle_cycle();
    chk("b2b_rsp", 64'(rsp_cnt - r0), 64'd20);
    chk("b2b_acc", 64'(acc_cnt - a0), 64'd20);

    for (int k = 0; k < 30; k++) begin
      w = ($urandom_range(0, 4) == 0) ?
          $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 4);
      txn(1'($urandom), rnd_addr(), $urandom, w, 1'($urandom),
          1'($urandom), -1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter TIMEOUT, default 16: maximum ACCESS-phase cycles before the block aborts a transfer; legal range 2..255.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 pclk  in  1  clock; all state updates on the rising edge.
REQ-006 preset  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request from the local host.
REQ-008 cmd_ready  out  1  high when the block accepts a command this cycle.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_wdata  in  DATA_W  write data; ignored on reads.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data; valid with rsp_valid.
REQ-014 rsp_slverr  out  1  error status; valid with rsp_valid.
REQ-015 rsp_timeout  out  1  the transfer was aborted by timeout; valid with rsp_valid.
REQ-016 psel, penable, pwrite  out  1 each  APB requester controls.
REQ-017 paddr  out  ADDR_W; pwdata  out  DATA_W  APB requester address and write data.
REQ-018 prdata  in  DATA_W; pready  in  1; pslverr  in  1  APB completer response.

Function
REQ-019 The FSM has three states: IDLE, SETUP and ACCESS. IDLE goes to SETUP on cmd_valid&&cmd_ready. SETUP always goes to ACCESS. ACCESS goes to IDLE on pready=1 or on timeout. Otherwise ACCESS stays in ACCESS.
REQ-020 cmd_ready shall equal (state==IDLE). There is no combinational path from cmd_valid to cmd_ready.
REQ-021 On acceptance, the block registers cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata. These outputs stay stable through SETUP and ACCESS and do not change until the next acceptance.
REQ-022 Output levels by state:
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
  - IDLE: psel=0, penable=0.
REQ-023 Minimum latency: acceptance at cycle T, SETUP at T+1, ACCESS at T+2. If pready=1 at T+2, rsp_valid=1 at T+3 and cmd_ready=1 at T+3.
REQ-024 rsp_valid shall pulse for exactly one cycle, in the first IDLE cycle after ACCESS ends.
REQ-025 On normal completion:
  - rsp_rdata gets prdata sampled at the completing edge on reads, and 0 on writes.
  - rsp_slverr gets pslverr sampled at the completing edge.
  - rsp_timeout = 0.
REQ-026 rsp_rdata, rsp_slverr and rsp_timeout hold their values until the next rsp_valid.
REQ-027 An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
REQ-028 Timeout occurs when the block is in ACCESS with pready=0 and the wait counter equals TIMEOUT-1. ACCESS therefore lasts at most TIMEOUT cycles.
REQ-029 On timeout, the block returns to IDLE with psel=0 and penable=0. The response is rsp_rdata=0, rsp_slverr=1, rsp_timeout=1.
REQ-030 pready=1 in the timeout cycle is a normal completion; pready has priority over timeout.
REQ-031 pready and pslverr are ignored outside ACCESS.
REQ-032 A command with cmd_valid=1 held during a transfer is not accepted until IDLE. The block accepts exactly one command per IDLE cycle in which cmd_valid=1.

Reset
REQ-033 When preset=1, the block enters IDLE and drives:
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0.
  - wait counter = 0.
  - cmd_ready=1 in the first cycle after release.
REQ-034 Reset during SETUP or ACCESS abandons the transfer with no rsp_valid. psel=0 from the edge that samples preset=1.

Verification
REQ-035 Write with a zero-wait completer: cmd addr=0x10, wdata=0xA5A5_0001, write=1 at T.
  - T+1: psel=1, penable=0.
  - T+2: psel=1, penable=1, pready=1.
  - T+3: rsp_valid=1, rsp_slverr=0.
REQ-036 Read with 3 wait states: addr=0x10. pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0xA5A5_0001. Required: rsp_valid at T+6, rsp_rdata=0xA5A5_0001, paddr stable throughout.
REQ-037 Error: read of addr=0x40 with pslverr=1 and pready=1 on the first ACCESS cycle. Required: rsp_slverr=1, rsp_timeout=0.
REQ-038 Timeout with TIMEOUT=16 and pready stuck at 0. Required:
  - 16 ACCESS cycles, then psel=0 and rsp_valid=1.
  - rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - Second case: pready=1 exactly on the 16th ACCESS cycle gives a normal completion.
REQ-039 Back-to-back: cmd_valid held high for 20 random read/write commands against a RAM completer. Required:
  - Exactly 20 rsp_valid pulses.
  - Each read returns the last data written to that address.
  - At least 3 cycles between acceptances.
REQ-040 Reset in the second ACCESS wait cycle. Required: psel=0 next cycle, no rsp_valid, cmd_ready=1 after release.
